// File: rtl/bitwise_operand_loader_if.sv
// Handshake bundle between the beat source, the operand loader and the downstream bitwise stage.
interface bitwise_operand_loader_if #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CHUNK = 5
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [CHUNK-1:0] in_data;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             op_ready;
    logic             loading;

    modport master (
        output clear, in_valid, in_data, op_ready,
        input  in_ready, op_a, op_b, op_valid, loading
    );

    modport slave (
        input  clear, in_valid, in_data, op_ready,
        output in_ready, op_a, op_b, op_valid, loading
    );
endinterface

// File: rtl/bitwise_operand_loader.sv
// Collects operands A and B from a narrow beat stream (LSB chunk first) and
// presents them in parallel, held stable, until the downstream stage takes them.
module bitwise_operand_loader #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CHUNK = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bitwise_operand_loader_if.slave ld_if
);
    localparam int unsigned      BEATS     = WIDTH / CHUNK;
    localparam int unsigned      CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'd0,
        S_LOAD_B  = 2'd1,
        S_PRESENT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             in_ready_q;
    logic             op_valid_q;
    logic             loading_q;
    logic             last_beat;

    assign last_beat = (cnt_q == LAST_BEAT);

    // Next-state: clear wins over any beat accept or output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        if (ld_if.clear) begin
            state_d = S_LOAD_A;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
        end else begin
            unique case (state_q)
                S_LOAD_A, S_LOAD_B: begin
                    if (ld_if.in_valid) begin
                        for (int unsigned k = 0; k < BEATS; k++) begin
                            if (cnt_q == CNT_W'(k)) begin
                                if (state_q == S_LOAD_A) begin
                                    a_d[k*CHUNK +: CHUNK] = ld_if.in_data;
                                end else begin
                                    b_d[k*CHUNK +: CHUNK] = ld_if.in_data;
                                end
                            end
                        end
                        cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_PRESENT;
                        end
                    end
                end
                S_PRESENT: begin
                    if (ld_if.op_ready) begin
                        state_d = S_LOAD_A;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                end
            endcase
        end
    end

    // Status outputs are registered copies of the next-state decode, so they
    // track the state register exactly and drop with it on asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD_A;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            in_ready_q <= 1'b1;
            op_valid_q <= 1'b0;
            loading_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            in_ready_q <= (state_d != S_PRESENT);
            op_valid_q <= (state_d == S_PRESENT);
            loading_q  <= (cnt_d != '0) || (state_d != S_LOAD_A);
        end
    end

    assign ld_if.in_ready = in_ready_q;
    assign ld_if.op_valid = op_valid_q;
    assign ld_if.loading  = loading_q;
    assign ld_if.op_a     = a_q;
    assign ld_if.op_b     = b_q;

endmodule
